test_020: RTL and testbench

Self-checking compute block with a method-call interface. It holds six 32-bit field registers (a–f) and a 16-entry 32-bit array `mem2`, all externally accessible. The `test` method fills `mem2` from fields a and b, reads it back, sums it, and reports pass/fail on `test_return`. It sits behind a simple req/busy handshake as a leaf worker under a controller or testbench.

---
 rtl/test_020_pkg.sv | 17 +
 rtl/test_020_if.sv | 22 ++
 rtl/test_020_mem2_ram.sv | 37 +++
 rtl/test_020.sv | 128 ++++++++++++
 tb/tb_test_020.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/test_020_pkg.sv
// Shared types and constants for the test_020 self-checking compute block.
package test_020_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WRITE,
        READ,
        CHECK
    } state_t;

    localparam int unsigned MEM2_LENGTH = 16;
    localparam int unsigned MEM2_ADDR_W = 4;
    localparam logic [31:0] A_INIT = 32'd1;
    localparam logic [31:0] B_INIT = 32'd2;

endpackage

// File: rtl/test_020_if.sv
// Method handshake (test_req/busy/return) and external mem2 port of test_020.
interface test_020_if;
    logic        test_req;
    logic        test_busy;
    logic        test_return;
    logic [31:0] mem2_address;
    logic        mem2_we;
    logic        mem2_oe;
    logic [31:0] mem2_din;
    logic [31:0] mem2_dout;
    logic [31:0] mem2_length;

    modport master (
        output test_req, mem2_address, mem2_we, mem2_oe, mem2_din,
        input  test_busy, test_return, mem2_dout, mem2_length
    );

    modport slave (
        input  test_req, mem2_address, mem2_we, mem2_oe, mem2_din,
        output test_busy, test_return, mem2_dout, mem2_length
    );
endinterface

// File: rtl/test_020_mem2_ram.sv
// 16x32 true dual-port RAM with registered reads; port a (internal) wins write collisions.
module test_020_mem2_ram
    import test_020_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MEM2_ADDR_W-1:0] a_addr,
    input  logic                   a_we,
    input  logic                   a_re,
    input  logic [31:0]            a_din,
    output logic [31:0]            a_dout,
    input  logic [MEM2_ADDR_W-1:0] b_addr,
    input  logic                   b_we,
    input  logic                   b_re,
    input  logic [31:0]            b_din,
    output logic [31:0]            b_dout
);

    logic [31:0] mem [MEM2_LENGTH];

    // Port a is written last so it overrides port b on an address clash.
    always_ff @(posedge clk) begin
        if (b_we) mem[b_addr] <= b_din;
        if (a_we) mem[a_addr] <= a_din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_dout <= '0;
            b_dout <= '0;
        end else begin
            if (a_re) a_dout <= mem[a_addr];
            if (b_re) b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/test_020.sv
// Field registers, test-method FSM, accumulator and index around the mem2 RAM.
module test_020
    import test_020_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    test_020_if.slave   bus,
    input  logic [31:0] a_in,
    input  logic        a_we,
    output logic [31:0] a_out,
    input  logic [31:0] b_in,
    input  logic        b_we,
    output logic [31:0] b_out,
    input  logic [31:0] c_in,
    input  logic        c_we,
    output logic [31:0] c_out,
    input  logic [31:0] d_in,
    input  logic        d_we,
    output logic [31:0] d_out,
    input  logic [31:0] e_in,
    input  logic        e_we,
    output logic [31:0] e_out,
    input  logic [31:0] f_in,
    input  logic        f_we,
    output logic [31:0] f_out
);

    state_t      state, state_nxt;
    logic [4:0]  idx;
    logic [31:0] acc;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic        unused_addr_bits;

    assign bus.mem2_length = 32'(MEM2_LENGTH);
    assign unused_addr_bits = ^bus.mem2_address[31:MEM2_ADDR_W];

    test_020_mem2_ram u_ram (
        .clk    (clk),
        .reset  (reset),
        .a_addr (idx[MEM2_ADDR_W-1:0]),
        .a_we   (ram_we),
        .a_re   (ram_re),
        .a_din  (acc),
        .a_dout (ram_rdata),
        .b_addr (bus.mem2_address[MEM2_ADDR_W-1:0]),
        .b_we   (bus.mem2_we),
        .b_re   (bus.mem2_oe),
        .b_din  (bus.mem2_din),
        .b_dout (bus.mem2_dout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.test_req) state_nxt = INIT;
            INIT:    state_nxt = WRITE;
            WRITE:   if (idx == 5'd15) state_nxt = READ;
            READ:    if (idx == 5'd16) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.test_busy = (state != IDLE);
        ram_we        = (state == WRITE);
        ram_re        = (state == READ) && !idx[4];
    end

    // READ runs 17 cycles: reads issue for idx 0..15, data lands one cycle later (idx 1..16).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_out           <= A_INIT;
            b_out           <= B_INIT;
            c_out           <= '0;
            d_out           <= '0;
            e_out           <= '0;
            f_out           <= '0;
            acc             <= '0;
            idx             <= '0;
            bus.test_return <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (a_we) a_out <= a_in;
                    if (b_we) b_out <= b_in;
                    if (c_we) c_out <= c_in;
                    if (d_we) d_out <= d_in;
                    if (e_we) e_out <= e_in;
                    if (f_we) f_out <= f_in;
                end
                INIT: begin
                    acc   <= b_out;
                    idx   <= '0;
                    c_out <= (b_out << 4) + (a_out << 7) - (a_out << 3);
                    d_out <= '0;
                end
                WRITE: begin
                    acc   <= acc + a_out;
                    d_out <= d_out + 32'd1;
                    if (idx == 5'd15) begin
                        idx   <= '0;
                        e_out <= '0;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                READ: begin
                    idx <= idx + 5'd1;
                    if (idx != 5'd0) e_out <= e_out + ram_rdata;
                end
                CHECK: begin
                    f_out           <= {31'd0, e_out == c_out};
                    bus.test_return <= (e_out == c_out);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_test_020.sv
// Directed scoreboard bench for test_020: expectations queued at stimulus, checked on DUT output.
module tb_test_020;
    logic        clk;
    logic        reset;
    logic [31:0] a_in, b_in, c_in, d_in, e_in, f_in;
    logic        a_we, b_we, c_we, d_we, e_we, f_we;
    logic [31:0] a_out, b_out, c_out, d_out, e_out, f_out;

    test_020_if bus();

    test_020 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .a_in  (a_in), .a_we (a_we), .a_out (a_out),
        .b_in  (b_in), .b_we (b_we), .b_out (b_out),
        .c_in  (c_in), .c_we (c_we), .c_out (c_out),
        .d_in  (d_in), .d_we (d_we), .d_out (d_out),
        .e_in  (e_in), .e_we (e_we), .e_out (e_out),
        .f_in  (f_in), .f_we (f_we), .f_out (f_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q [$];
    int vectors = 0;
    int miscompares = 0;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    // Pulse test_req for one sampled edge, then count busy cycles (bounded).
    task automatic run_once(output int busy_cycles);
        busy_cycles = 0;
        bus.test_req = 1'b1;
        @(negedge clk);
        bus.test_req = 1'b0;
        while (bus.test_busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic write_ab(input logic [31:0] av, input logic [31:0] bv);
        a_in = av; b_in = bv; a_we = 1'b1; b_we = 1'b1;
        @(negedge clk);
        a_we = 1'b0; b_we = 1'b0;
    endtask

    task automatic ext_read(input logic [31:0] addr);
        bus.mem2_address = addr;
        bus.mem2_oe = 1'b1;
        @(negedge clk);
        bus.mem2_oe = 1'b0;
    endtask

    initial begin
        int n;
        int lows;
        reset = 1'b0;
        {a_in, b_in, c_in, d_in, e_in, f_in} = '0;
        {a_we, b_we, c_we, d_we, e_we, f_we} = '0;
        bus.test_req = 1'b0;
        bus.mem2_address = '0;
        bus.mem2_we = 1'b0;
        bus.mem2_oe = 1'b0;
        bus.mem2_din = '0;

        repeat (3) @(negedge clk);
        expect_val(32'd0); check("rst_busy", {31'd0, bus.test_busy});
        expect_val(32'd0); check("rst_return", {31'd0, bus.test_return});
        expect_val(32'd1); check("rst_a", a_out);
        expect_val(32'd2); check("rst_b", b_out);
        expect_val(32'd0); check("rst_c", c_out);
        expect_val(32'd0); check("rst_dout", bus.mem2_dout);
        expect_val(32'd16); check("mem2_length", bus.mem2_length);
        reset = 1'b1;
        @(negedge clk);

        // a=1, b=2
        run_once(n);
        expect_val(32'd35);  check("busy_len", n);
        expect_val(32'd1);   check("ret_1_2", {31'd0, bus.test_return});
        expect_val(32'd152); check("c_1_2", c_out);
        expect_val(32'd152); check("e_1_2", e_out);
        expect_val(32'd16);  check("d_1_2", d_out);
        expect_val(32'd1);   check("f_1_2", f_out);

        // Held request: one idle cycle between back-to-back runs
        bus.test_req = 1'b1;
        @(negedge clk);
        n = 0;
        while (bus.test_busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        expect_val(32'd35); check("held_busy_len", n);
        lows = 0;
        while (bus.test_busy === 1'b0 && lows < 10) begin
            lows++;
            expect_val(32'd1); check("held_ret", {31'd0, bus.test_return});
            @(negedge clk);
        end
        expect_val(32'd1); check("held_gap", lows);
        bus.test_req = 1'b0;
        n = 0;
        while (bus.test_busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        expect_val(32'd1); check("held_ret_end", {31'd0, bus.test_return});

        // a=3, b=5
        write_ab(32'd3, 32'd5);
        expect_val(32'd3); check("wr_a", a_out);
        run_once(n);
        expect_val(32'd35);  check("busy_len_3_5", n);
        expect_val(32'd440); check("c_3_5", c_out);
        expect_val(32'd440); check("e_3_5", e_out);
        expect_val(32'd1);   check("ret_3_5", {31'd0, bus.test_return});
        for (int k = 0; k < 16; k++) begin
            ext_read(32'(k));
            expect_val(32'(5 + 3 * k)); check($sformatf("mem2_%0d", k), bus.mem2_dout);
        end

        // Wraparound: a=2^30, b=0
        write_ab(32'h4000_0000, 32'd0);
        run_once(n);
        expect_val(32'd0); check("c_wrap", c_out);
        expect_val(32'd0); check("e_wrap", e_out);
        expect_val(32'd1); check("ret_wrap", {31'd0, bus.test_return});
        ext_read(32'd4);
        expect_val(32'd0); check("mem2_4_wrap", bus.mem2_dout);

        // Field writes ignored while busy
        write_ab(32'd1, 32'd2);
        bus.test_req = 1'b1;
        @(negedge clk);
        bus.test_req = 1'b0;
        a_in = 32'd7; a_we = 1'b1;
        repeat (3) @(negedge clk);
        a_we = 1'b0;
        expect_val(32'd1); check("a_busy_hold", a_out);
        n = 0;
        while (bus.test_busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        expect_val(32'd1);   check("a_after_run", a_out);
        expect_val(32'd152); check("c_we_busy", c_out);
        expect_val(32'd152); check("e_we_busy", e_out);
        expect_val(32'd1);   check("ret_we_busy", {31'd0, bus.test_return});

        // External port: address bits above [3:0] ignored, oe=0 holds
        bus.mem2_address = 32'h13; bus.mem2_din = 32'hDEAD_BEEF; bus.mem2_we = 1'b1;
        @(negedge clk);
        bus.mem2_we = 1'b0;
        ext_read(32'd3);
        expect_val(32'hDEAD_BEEF); check("alias_0x13", bus.mem2_dout);
        bus.mem2_address = 32'd5;
        repeat (2) @(negedge clk);
        expect_val(32'hDEAD_BEEF); check("oe0_hold", bus.mem2_dout);
        ext_read(32'd5);
        expect_val(32'd7); check("mem2_5", bus.mem2_dout);

        // Reset mid-run
        bus.test_req = 1'b1;
        @(negedge clk);
        bus.test_req = 1'b0;
        repeat (10) @(negedge clk);
        expect_val(32'd1); check("busy_pre_rst", {31'd0, bus.test_busy});
        reset = 1'b0;
        #1;
        expect_val(32'd0); check("busy_mid_rst", {31'd0, bus.test_busy});
        expect_val(32'd0); check("ret_mid_rst", {31'd0, bus.test_return});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
